// File: rtl/chirp_sweep_ctrl.sv
// chirp_sweep_ctrl: frequency-chirp sequencer that drives an NCO control word.
// Steps the control word up, down or in a triangle between two programmed
// limits. Each value is held for dwell+1 cycles. Sweeps repeat N times, or run
// continuously when N=0.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   ena         global enable; when low all state holds and pulses read 0
//   cfg_we      config write strobe (accepted only when idle and enabled)
//   cfg_addr    0 f_start, 1 f_stop, 2 step, 3 dwell, 4 ctrl
//   cfg_data    config write data
//   start       sweep start request (level-sampled in IDLE)
//   stop        abort request, takes priority over start
//   fcw         frequency control word to the NCO
//   nco_en      NCO enable, high while sweeping
//   busy        high whenever not IDLE
//   sync        one-cycle pulse on the first cycle of every sweep
//   sweep_done  one-cycle pulse after the final dwell of every sweep
//
// state | meaning
// IDLE  | no sweep, fcw=0, NCO disabled, config writable
// UP    | ascending values, clamped at the stop value
// DOWN  | descending values, clamped at the start value

module chirp_sweep_ctrl #(
    parameter int FCW_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [7:0]       cfg_data,
    input  logic             start,
    input  logic             stop,
    output logic [FCW_W-1:0] fcw,
    output logic             nco_en,
    output logic             busy,
    output logic             sync,
    output logic             sweep_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] f_start;
    logic [7:0] f_stop;
    logic [7:0] step;
    logic [7:0] dwell;
    logic [7:0] ctrl;
    logic [7:0] dwell_cnt;
    logic [3:0] sweep_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_start <= 8'h10;
            f_stop  <= 8'h80;
            step    <= 8'h01;
            dwell   <= 8'h00;
            ctrl    <= 8'h00;
        end else if (ena && cfg_we && !busy) begin
            case (cfg_addr)
                3'd0:    f_start <= cfg_data;
                3'd1:    f_stop  <= cfg_data;
                3'd2:    step    <= cfg_data;
                3'd3:    dwell   <= cfg_data;
                3'd4:    ctrl    <= cfg_data;
                default: ;
            endcase
        end
    end

    logic [7:0]       step_eff;
    logic [FCW_W-1:0] s_val;
    logic [FCW_W-1:0] p_val;
    logic [FCW_W-1:0] inc;
    logic [FCW_W:0]   sum;
    logic [FCW_W:0]   diff;
    logic [FCW_W-1:0] up_next;
    logic [FCW_W-1:0] dn_next;
    logic             mode_down;
    logic             mode_tri;
    logic             at_top;
    logic             at_bot;
    logic             dwell_exp;
    logic             can_turn;
    logic             sweep_end;
    logic             repeat_sweep;
    logic [FCW_W-1:0] first_val;
    state_t           first_state;

    assign step_eff  = (step == 8'h00) ? 8'h01 : step;
    assign s_val     = FCW_W'({f_start, 8'h00});
    assign p_val     = FCW_W'({f_stop, 8'h00});
    assign inc       = FCW_W'({4'h0, step_eff, 4'h0});

    // One extra bit so an increment past the top of the word range still
    // compares correctly against the stop value.
    assign sum       = {1'b0, fcw} + {1'b0, inc};
    assign up_next   = (sum > {1'b0, p_val}) ? p_val : sum[FCW_W-1:0];

    // The top bit of diff is the borrow; any borrow means we went below S.
    assign diff      = {1'b0, fcw} - {1'b0, inc};
    assign dn_next   = (diff[FCW_W] || (diff[FCW_W-1:0] < s_val)) ? s_val : diff[FCW_W-1:0];

    assign mode_down = (ctrl[1:0] == 2'b01);
    assign mode_tri  = (ctrl[1:0] == 2'b10);
    assign at_top    = (fcw >= p_val);
    assign at_bot    = (fcw <= s_val);
    assign dwell_exp = (dwell_cnt == 8'h00);

    // Triangle only turns around when there is a real range; a degenerate
    // range collapses the whole sweep to the single start value.
    assign can_turn  = mode_tri && (s_val < p_val);

    assign sweep_end = dwell_exp &&
                       (((state == UP) && at_top && !can_turn) ||
                        ((state == DOWN) && at_bot));

    assign repeat_sweep = (sweep_cnt == 4'd0) || (sweep_cnt > 4'd1);
    assign first_val    = mode_down ? p_val : s_val;
    assign first_state  = mode_down ? DOWN : UP;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            fcw        <= '0;
            nco_en     <= 1'b0;
            busy       <= 1'b0;
            sync       <= 1'b0;
            sweep_done <= 1'b0;
            dwell_cnt  <= 8'h00;
            sweep_cnt  <= 4'd0;
        end else if (!ena) begin
            sync       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sync       <= 1'b0;
            sweep_done <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                fcw       <= '0;
                nco_en    <= 1'b0;
                busy      <= 1'b0;
                dwell_cnt <= 8'h00;
                sweep_cnt <= 4'd0;
            end else if (sweep_end) begin
                sweep_done <= 1'b1;
                if (repeat_sweep) begin
                    state     <= first_state;
                    fcw       <= first_val;
                    sync      <= 1'b1;
                    dwell_cnt <= dwell;
                    // N=0 is continuous: the count stays parked at zero.
                    if (sweep_cnt != 4'd0)
                        sweep_cnt <= sweep_cnt - 4'd1;
                end else begin
                    state     <= IDLE;
                    fcw       <= '0;
                    nco_en    <= 1'b0;
                    busy      <= 1'b0;
                    dwell_cnt <= 8'h00;
                    sweep_cnt <= 4'd0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= first_state;
                            fcw       <= first_val;
                            nco_en    <= 1'b1;
                            busy      <= 1'b1;
                            sync      <= 1'b1;
                            dwell_cnt <= dwell;
                            sweep_cnt <= ctrl[7:4];
                        end
                    end
                    UP: begin
                        if (!dwell_exp) begin
                            dwell_cnt <= dwell_cnt - 8'h01;
                        end else if (!at_top) begin
                            fcw       <= up_next;
                            dwell_cnt <= dwell;
                        end else begin
                            // Peak reached in triangle mode; fcw equals P here,
                            // so dn_next is max(P-I, S).
                            state     <= DOWN;
                            fcw       <= dn_next;
                            dwell_cnt <= dwell;
                        end
                    end
                    DOWN: begin
                        if (!dwell_exp) begin
                            dwell_cnt <= dwell_cnt - 8'h01;
                        end else begin
                            fcw       <= dn_next;
                            dwell_cnt <= dwell;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        fcw    <= '0;
                        nco_en <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chirp_sweep_ctrl.sv
// tb_chirp_sweep_ctrl: directed test of chirp_sweep_ctrl with hand-computed
// expected control-word sequences.

module tb_chirp_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        start;
    logic        stop;
    logic [15:0] fcw;
    logic        nco_en;
    logic        busy;
    logic        sync;
    logic        sweep_done;

    int n_vec;
    int n_err;
    logic [15:0] seq[$];

    chirp_sweep_ctrl #(.FCW_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .stop       (stop),
        .fcw        (fcw),
        .nco_en     (nco_en),
        .busy       (busy),
        .sync       (sync),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic abort();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic check_idle(input string tag, input logic done_exp);
        chk({tag, "_fcw"},  fcw,        0);
        chk({tag, "_busy"}, busy,       0);
        chk({tag, "_nco"},  nco_en,     0);
        chk({tag, "_done"}, sweep_done, done_exp);
    endtask

    // Walks the queued sequence; the current cycle is element 0 (sync cycle).
    task automatic run_seq(input string tag, input logic done0);
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) tick();
            chk($sformatf("%s_fcw%0d", tag, i), fcw, seq[i]);
            chk($sformatf("%s_sync%0d", tag, i), sync, (i == 0));
            chk($sformatf("%s_done%0d", tag, i), sweep_done, (i == 0) ? done0 : 1'b0);
            chk($sformatf("%s_busy%0d", tag, i), busy, 1);
        end
    endtask

    task automatic setup(input logic [7:0] fs, input logic [7:0] fp,
                         input logic [7:0] st, input logic [7:0] dw, input logic [7:0] ct);
        cfg_wr(3'd0, fs);
        cfg_wr(3'd1, fp);
        cfg_wr(3'd2, st);
        cfg_wr(3'd3, dw);
        cfg_wr(3'd4, ct);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0;
        cfg_data = 8'h00; start = 1'b0; stop = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check_idle("rst", 0);
        chk("rst_sync", sync, 0);

        // Default registers, reset in the middle of a sweep, then readback.
        go();
        seq = '{16'h1000, 16'h1010, 16'h1020, 16'h1030};
        run_seq("dflt", 0);
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check_idle("midrst", 0);
        go();
        seq = '{16'h1000, 16'h1010, 16'h1020};
        run_seq("readback", 0);
        abort();
        check_idle("abort0", 0);

        // Up sweep with dwell=1, single sweep.
        setup(8'h10, 8'h12, 8'h10, 8'h01, 8'h10);
        go();
        seq = '{16'h1000, 16'h1000, 16'h1100, 16'h1100, 16'h1200, 16'h1200};
        run_seq("up", 0);
        tick();
        check_idle("up_end", 1);
        tick();
        chk("up_done_clr", sweep_done, 0);

        // Clamp at the stop value.
        setup(8'h10, 8'h18, 8'h30, 8'h00, 8'h10);
        go();
        seq = '{16'h1000, 16'h1300, 16'h1600, 16'h1800};
        run_seq("clamp", 0);
        tick();
        check_idle("clamp_end", 1);

        // Triangle, two sweeps.
        setup(8'h10, 8'h12, 8'h10, 8'h00, 8'h22);
        go();
        seq = '{16'h1000, 16'h1100, 16'h1200, 16'h1100, 16'h1000};
        run_seq("tri1", 0);
        tick();
        run_seq("tri2", 1);
        tick();
        check_idle("tri_end", 1);
        tick();
        chk("tri_done_clr", sweep_done, 0);

        // Down sweep.
        setup(8'h10, 8'h12, 8'h10, 8'h00, 8'h11);
        go();
        seq = '{16'h1200, 16'h1100, 16'h1000};
        run_seq("down", 0);
        tick();
        check_idle("down_end", 1);

        // f_start >= f_stop: one value, then end.
        setup(8'h20, 8'h12, 8'h10, 8'h00, 8'h10);
        go();
        seq = '{16'h2000};
        run_seq("degen", 0);
        tick();
        check_idle("degen_end", 1);

        // step=0 behaves as step=1.
        setup(8'h10, 8'h80, 8'h00, 8'h00, 8'h00);
        go();
        seq = '{16'h1000, 16'h1010, 16'h1020};
        run_seq("step0", 0);
        abort();
        check_idle("step0_abort", 0);

        // Continuous sweep, write while busy, abort mid-sweep.
        setup(8'h10, 8'h12, 8'h10, 8'h00, 8'h00);
        go();
        seq = '{16'h1000, 16'h1100, 16'h1200};
        run_seq("cont1", 0);
        tick();
        seq = '{16'h1000};
        run_seq("cont2", 1);
        cfg_wr(3'd0, 8'h11);
        chk("cont_fcw", fcw, 16'h1100);
        abort();
        check_idle("cont_abort", 0);
        go();
        seq = '{16'h1000, 16'h1100};
        run_seq("cont_ro", 0);
        abort();

        // Enable low mid-dwell freezes the dwell counter.
        setup(8'h10, 8'h12, 8'h10, 8'h03, 8'h10);
        go();
        seq = '{16'h1000, 16'h1000, 16'h1000};
        run_seq("ena", 0);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("frz_fcw%0d", i), fcw, 16'h1000);
            chk($sformatf("frz_busy%0d", i), busy, 1);
        end
        ena = 1'b1;
        tick();
        chk("resume_hold", fcw, 16'h1000);
        tick();
        chk("resume_step", fcw, 16'h1100);
        abort();

        // Start while disabled is ignored.
        ena = 1'b0;
        start = 1'b1;
        tick(); tick();
        check_idle("ena0_start", 0);
        start = 1'b0;
        ena = 1'b1;
        tick();
        check_idle("ena0_after", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chirp_sweep_ctrl.md
CHIRP_SWEEP_CTRL -- requirements
Module: chirp_sweep_ctrl

Interface
REQ-001 Parameter FCW_W, default 16, width of frequency control word output.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  global enable; 0 freezes all state and outputs (pulses forced 0).
REQ-005 cfg_we  input  1  config write strobe, one write per cycle.
REQ-006 cfg_addr  input  3  register select: 0 f_start, 1 f_stop, 2 step, 3 dwell, 4 ctrl; 5-7 ignored.
REQ-007 cfg_data  input  8  write data.
REQ-008 start  input  1  level-sampled sweep start request.
REQ-009 stop  input  1  level-sampled abort request; priority over start.
REQ-010 fcw  output  FCW_W  frequency control word to NCO, registered.
REQ-011 nco_en  output  1  NCO enable, high while sweeping.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 sync  output  1  one-cycle pulse on first cycle of every sweep.
REQ-014 sweep_done  output  1  one-cycle pulse after final dwell of every sweep.

Function
REQ-015 Register values: start value S={f_start,8'h00}, stop value P={f_stop,8'h00}, increment I={4'h0,step,4'h0}, step 0 treated as 1; hold time per value = dwell+1 cycles.
REQ-016 ctrl[1:0] mode: 00 up, 01 down, 10 triangle, 11 treated as up; ctrl[7:4] sweep count N, N=0 continuous.
REQ-017 Config writes accepted only when busy=0 and ena=1; writes while busy have no effect.
REQ-018 States: IDLE, UP, DOWN; IDLE outputs fcw=0, nco_en=0, busy=0.
REQ-019 IDLE with start=1, stop=0, ena=1 at edge t: at t+1 fcw=first value (S for up/triangle, P for down), nco_en=1, busy=1, sync=1, sweep counter loaded with N.
REQ-020 UP: after dwell+1 cycles at value v, next value = min(v+I, P) computed in FCW_W+1 bits; never exceeds P.
REQ-021 DOWN: next value = max(v-I, S) with borrow detection; never below S.
REQ-022 Triangle: on dwell expiry at P, transition UP->DOWN with next value max(P-I, S); peak held for one dwell only; sweep ends at S.
REQ-023 Sweep end = dwell expiry at P (up), at S (down, triangle descending); next cycle sweep_done=1.
REQ-024 On sweep end: if N=0 or remaining count>1, same cycle as sweep_done also restarts (fcw=first value, sync=1, count decremented); else returns to IDLE (fcw=0, nco_en=0, busy=0) in that cycle.
REQ-025 f_start>=f_stop: sweep is one value (S for up/triangle, P for down) held one dwell, then sweep end.
REQ-026 stop=1 with ena=1 in any state: next cycle IDLE, no sweep_done pulse; start ignored while busy.
REQ-027 ena=0: dwell counter, fcw, state, sweep counter hold; sync and sweep_done forced 0; start, stop, cfg_we ignored.

Reset
REQ-028 rst_n=0 at an edge: next cycle state IDLE, fcw=0, nco_en=0, busy=0, sync=0, sweep_done=0, counters 0, regardless of ena or ongoing sweep.
REQ-029 Reset register values: f_start=0x10, f_stop=0x80, step=0x01, dwell=0x00, ctrl=0x00.

Verification
REQ-030 Reset: rst_n low 2 cycles mid-sweep -> fcw=0, nco_en=0, busy=0; readback by starting with defaults gives fcw 0x1000, 0x1010, 0x1020 on consecutive cycles.
REQ-031 Up, f_start=0x10, f_stop=0x12, step=0x10, dwell=1, ctrl=0x10 -> fcw 0x1000,0x1000,0x1100,0x1100,0x1200,0x1200, then sweep_done=1 with IDLE.
REQ-032 Clamp, f_start=0x10, f_stop=0x18, step=0x30, dwell=0, ctrl=0x10 -> fcw 0x1000,0x1300,0x1600,0x1800, then done.
REQ-033 Triangle, f_start=0x10, f_stop=0x12, step=0x10, dwell=0, ctrl=0x22 -> 0x1000,0x1100,0x1200,0x1100,0x1000, restart with sync=1, repeat once, two sweep_done pulses, IDLE.
REQ-034 Continuous sweep, stop asserted mid-sweep -> IDLE next cycle, no sweep_done; cfg write during busy leaves register unchanged on next sweep.
REQ-035 ena=0 for 5 cycles mid-dwell (dwell=3) -> fcw frozen, dwell resumes remaining count after ena=1; start with ena=0 ignored.
